ram_cmd_arbiter: RTL and testbench

- Shares the 10-bit command port of the single-port SPI slave RAM (din[9:8] opcode: 00 set-wr-addr, 01 write-data, 10 set-rd-addr, 11 read) between two requesters.
- Accepts one whole transaction from a requester (write addr+data, or read addr) and expands it into the two-beat RAM command sequence.
- For reads, captures dout on tx_valid and routes the response back to the owning requester.
- Sits between the SPI-slave/host front ends and the RAM; the only driver of RAM rx_valid/din.

---
 rtl/ram_cmd_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter.sv
// Two-requester arbiter expanding whole transactions into SPI-RAM command beats.
// Optional macro ADDR_CACHE_EN shadows the RAM address registers to skip redundant ADDR beats.
module ram_cmd_arbiter #(
  parameter int ADDR_SIZE   = 8,
  parameter int RSP_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_wr,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [2*ADDR_SIZE-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic                   rsp_err,
  output logic [ADDR_SIZE-1:0]   rsp_rdata,
  output logic                   ram_rx_valid,
  output logic [ADDR_SIZE+1:0]   ram_din,
  input  logic [ADDR_SIZE-1:0]   ram_dout,
  input  logic                   ram_tx_valid,
  output logic                   busy
);

  localparam int DW = ADDR_SIZE;
  localparam int CW = ADDR_SIZE + 2;
  localparam logic [3:0] WAIT_LAST = 4'(RSP_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_RESP} state_t;

  state_t         state;
  logic           rr_ptr;
  logic           owner;
  logic           cur_wr;
  logic [DW-1:0]  cur_wdata;
  logic [3:0]     wait_cnt;

  logic           winner;
  logic           sel_wr;
  logic [DW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           hit;
  logic           timeout_evt;

  function automatic logic [CW-1:0] addr_cmd(input logic wr, input logic [DW-1:0] a);
    return {(wr ? 2'b00 : 2'b10), a};
  endfunction

  function automatic logic [CW-1:0] data_cmd(input logic wr, input logic [DW-1:0] d);
    return wr ? {2'b01, d} : {2'b11, {DW{1'b0}}};
  endfunction

  // On a tie the pointer decides; a lone requester always wins.
  always_comb begin
    winner    = (&req_valid) ? rr_ptr : req_valid[1];
    sel_wr    = req_wr[winner];
    sel_addr  = winner ? req_addr[2*DW-1:DW]  : req_addr[DW-1:0];
    sel_wdata = winner ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
  end

  assign timeout_evt = (state == S_WAIT) && !ram_tx_valid && (wait_cnt == WAIT_LAST);
  assign busy        = (state != S_IDLE);

`ifdef ADDR_CACHE_EN
  logic [DW-1:0] wr_sh;
  logic [DW-1:0] rd_sh;
  logic          wr_sh_vld;
  logic          rd_sh_vld;
  logic          issue_addr;

  assign hit = sel_wr ? (wr_sh_vld && (wr_sh == sel_addr))
                      : (rd_sh_vld && (rd_sh == sel_addr));
  assign issue_addr = (state == S_IDLE) && (|req_valid) && !hit;

  // Shadows mirror the RAM's reset value; a timeout leaves the RAM state unknown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sh     <= '0;
      rd_sh     <= '0;
      wr_sh_vld <= 1'b1;
      rd_sh_vld <= 1'b1;
    end else if (timeout_evt) begin
      wr_sh_vld <= 1'b0;
      rd_sh_vld <= 1'b0;
    end else if (issue_addr) begin
      if (sel_wr) begin
        wr_sh     <= sel_addr;
        wr_sh_vld <= 1'b1;
      end else begin
        rd_sh     <= sel_addr;
        rd_sh_vld <= 1'b1;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= 1'b0;
      owner        <= 1'b0;
      cur_wr       <= 1'b0;
      cur_wdata    <= '0;
      wait_cnt     <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      ram_rx_valid <= 1'b0;
      ram_din      <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            req_ready    <= winner ? 2'b10 : 2'b01;
            owner        <= winner;
            cur_wr       <= sel_wr;
            cur_wdata    <= sel_wdata;
            rr_ptr       <= ~winner;
            ram_rx_valid <= 1'b1;
            if (hit) begin
              state   <= S_DATA;
              ram_din <= data_cmd(sel_wr, sel_wdata);
            end else begin
              state   <= S_ADDR;
              ram_din <= addr_cmd(sel_wr, sel_addr);
            end
          end
        end
        S_ADDR: begin
          state        <= S_DATA;
          ram_rx_valid <= 1'b1;
          ram_din      <= data_cmd(cur_wr, cur_wdata);
        end
        S_DATA: begin
          ram_rx_valid <= 1'b0;
          ram_din      <= '0;
          if (cur_wr) begin
            state     <= S_RESP;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            rsp_err   <= 1'b0;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (ram_tx_valid) begin
            state     <= S_RESP;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            rsp_rdata <= ram_dout;
            rsp_err   <= 1'b0;
          end else if (timeout_evt) begin
            state     <= S_RESP;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter with a behavioural SPI-slave RAM model.
module tb_ram_cmd_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_rdata;
  logic        ram_rx_valid;
  logic [9:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;
  logic        busy;

  ram_cmd_arbiter #(.ADDR_SIZE(8), .RSP_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: commands consumed at the negedge of the beat cycle.
  logic [7:0] mem [256];
  logic [7:0] m_wa, m_ra;
  logic       tx_m, tx_en;
  logic [9:0] cmd_q [$];
  int         cmd_t [$];

  assign ram_tx_valid = tx_m & tx_en;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    m_wa = 8'h00; m_ra = 8'h00; tx_m = 1'b0; tx_en = 1'b1; ram_dout = 8'h00;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_wa = 8'h00; m_ra = 8'h00; tx_m = 1'b0;
    end else if (ram_rx_valid) begin
      cmd_q.push_back(ram_din);
      cmd_t.push_back(cyc);
      case (ram_din[9:8])
        2'b00: begin m_wa = ram_din[7:0]; tx_m = 1'b0; end
        2'b01: begin mem[m_wa] = ram_din[7:0]; tx_m = 1'b0; end
        2'b10: begin m_ra = ram_din[7:0]; tx_m = 1'b0; end
        default: begin ram_dout = mem[m_ra]; tx_m = 1'b1; end
      endcase
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, idx, act, exp);
  endtask

  task automatic fail_to(input string nm, input int idx);
    n_chk++;
    $display("FAIL %s[%0d]: got no event within bound, want event", nm, idx);
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_req_ready", idx, req_ready, 0);
    chk("rst_rsp_valid", idx, rsp_valid, 0);
    chk("rst_rsp_err", idx, rsp_err, 0);
    chk("rst_rsp_rdata", idx, rsp_rdata, 0);
    chk("rst_ram_rx_valid", idx, ram_rx_valid, 0);
    chk("rst_ram_din", idx, ram_din, 0);
    chk("rst_busy", idx, busy, 0);
  endtask

  // One transaction from a lone requester; called at a negedge with the DUT idle.
  task automatic run_txn(input int r, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input int idx, output int t_rdy, output int t_rsp);
    cmd_q.delete(); cmd_t.delete();
    req_valid[r] = 1'b1; req_wr[r] = wr;
    req_addr[r*8 +: 8] = a; req_wdata[r*8 +: 8] = d;
    t_rdy = -1; t_rsp = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin t_rdy = cyc; break; end
    end
    req_valid[r] = 1'b0;
    if (t_rdy < 0) fail_to("req_ready", idx);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid[r]) begin t_rsp = cyc; break; end
    end
    if (t_rsp < 0) fail_to("rsp_valid", idx);
  endtask

  typedef struct {
    int         req;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         ncmd;
    logic [9:0] c0;
    logic [9:0] c1;
    logic [7:0] rdata;
    bit         err;
    int         lat;
  } vec_t;

  vec_t vt [8];

  initial begin : main
    int t_rdy, t_rsp, viol, ng, got, post_ncmd, post_lat;
    int grants [4];
    logic prev_busy;
    logic [1:0] rdy_s;
    logic [9:0] post_c0;

    vt[0] = '{0, 1'b1, 8'h3C, 8'hA5, 2, 10'h03C, 10'h1A5, 8'h00, 1'b0, 2};
    vt[1] = '{1, 1'b0, 8'h3C, 8'h00, 2, 10'h23C, 10'h300, 8'hA5, 1'b0, 3};
    vt[2] = '{1, 1'b1, 8'h10, 8'h55, 2, 10'h010, 10'h155, 8'h00, 1'b0, 2};
    vt[3] = '{0, 1'b1, 8'h11, 8'h66, 2, 10'h011, 10'h166, 8'h00, 1'b0, 2};
    vt[4] = '{1, 1'b0, 8'h10, 8'h00, 2, 10'h210, 10'h300, 8'h55, 1'b0, 3};
`ifdef ADDR_CACHE_EN
    vt[5] = '{0, 1'b0, 8'h10, 8'h00, 1, 10'h300, 10'h000, 8'h55, 1'b0, 2};
    vt[6] = '{1, 1'b1, 8'h11, 8'h77, 1, 10'h177, 10'h000, 8'h00, 1'b0, 1};
    post_ncmd = 1; post_c0 = 10'h300; post_lat = 2;
`else
    vt[5] = '{0, 1'b0, 8'h10, 8'h00, 2, 10'h210, 10'h300, 8'h55, 1'b0, 3};
    vt[6] = '{1, 1'b1, 8'h11, 8'h77, 2, 10'h011, 10'h177, 8'h00, 1'b0, 2};
    post_ncmd = 2; post_c0 = 10'h200; post_lat = 3;
`endif
    vt[7] = '{0, 1'b0, 8'h11, 8'h00, 2, 10'h211, 10'h300, 8'h77, 1'b0, 3};

    rst_n = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset(0);
    rst_n = 1'b1;

    // Both requesters valid continuously from reset: grants must alternate.
    req_valid = 2'b11; req_wr = 2'b11; req_addr = 16'h3130; req_wdata = 16'h2211;
    viol = 0; ng = 0; prev_busy = 1'b0;
    for (int k = 0; k < 80 && ng < 4; k++) begin
      @(negedge clk);
      if (|req_ready) begin
        if (prev_busy) viol++;
        grants[ng] = (req_ready == 2'b10) ? 1 : ((req_ready == 2'b01) ? 0 : 9);
        ng++;
        if (ng == 4) req_valid = 2'b00;
      end
      prev_busy = busy;
    end
    req_valid = 2'b00;
    if (ng < 4) fail_to("rr_grants", ng);
    for (int g = 0; g < ng; g++) chk("rr_grant", g, grants[g], g % 2);
    chk("ready_while_busy", 0, viol, 0);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) begin got = 1; break; end
    end
    if (got == 0) fail_to("rr_drain", 0);

    for (int i = 0; i < 8; i++) begin
      run_txn(vt[i].req, vt[i].wr, vt[i].addr, vt[i].wdata, i, t_rdy, t_rsp);
      chk("ncmd", i, cmd_q.size(), vt[i].ncmd);
      if (cmd_q.size() >= 1) begin
        chk("cmd0", i, cmd_q[0], vt[i].c0);
        chk("cmd0_cycle", i, cmd_t[0], t_rdy);
      end
      if (vt[i].ncmd == 2 && cmd_q.size() >= 2) chk("cmd1", i, cmd_q[1], vt[i].c1);
      chk("rsp_latency", i, t_rsp - t_rdy, vt[i].lat);
      chk("rsp_err", i, rsp_err, vt[i].err);
      if (!vt[i].wr) chk("rsp_rdata", i, rsp_rdata, vt[i].rdata);
    end

    // Read timeout with tx_valid held low: 4 WAIT cycles after DATA.
    tx_en = 1'b0;
    run_txn(0, 1'b0, 8'h20, 8'h00, 100, t_rdy, t_rsp);
    chk("to_latency", 100, t_rsp - t_rdy, 6);
    chk("to_err", 100, rsp_err, 1);
    chk("to_rdata", 100, rsp_rdata, 0);

    // Reset in WAIT: no response, pointer back to requester 0.
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[7:0] = 8'h40;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin got = 1; break; end
    end
    req_valid = 2'b00;
    if (got == 0) fail_to("rw_ready", 200);
    repeat (2) @(negedge clk);
    chk("rw_busy_in_wait", 200, busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset(1);
    rst_n = 1'b1;
    tx_en = 1'b1;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (|rsp_valid) got++;
    end
    chk("rw_no_rsp", 200, got, 0);

    // Tie after reset goes to requester 0; read of addr 0x00.
    cmd_q.delete(); cmd_t.delete();
    req_valid = 2'b11; req_wr = 2'b00; req_addr = 16'h0000;
    t_rdy = -1; rdy_s = 2'b00;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (|req_ready) begin t_rdy = cyc; rdy_s = req_ready; break; end
    end
    req_valid = 2'b00;
    if (t_rdy < 0) fail_to("post_ready", 300);
    else chk("post_grant", 300, rdy_s, 2'b01);
    t_rsp = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin t_rsp = cyc; break; end
    end
    if (t_rsp < 0) fail_to("post_rsp", 300);
    chk("post_ncmd", 300, cmd_q.size(), post_ncmd);
    if (cmd_q.size() >= 1) chk("post_cmd0", 300, cmd_q[0], post_c0);
    chk("post_latency", 300, t_rsp - t_rdy, post_lat);
    chk("post_rdata", 300, rsp_rdata, 8'h00);
    chk("post_err", 300, rsp_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog[0]: got no finish, want finish");
    $fatal(1, "watchdog");
  end

endmodule
